ad9634_spi_master: RTL and testbench

- Single-transaction SPI master for the AD9634 3-wire serial port. It sits directly downstream of the SPI clock divider.
- It consumes the divider's div_clk as a pacing signal. div_clk is generated from the same clk, so no synchroniser is needed.
- It serialises one 24-bit frame (16-bit instruction plus 1 data byte), MSB first, and returns read data on a one-cycle response strobe.
- All logic runs on clk. SCLK is a registered output and is never a gated clock.

---
 rtl/ad9634_spi_master.sv | 188 ++++++++++++++++++
 tb/tb_ad9634_spi_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9634_spi_master.sv
// ============================================================================
// Module   : ad9634_spi_master
// Brief    : Single-frame 3-wire SPI master (16-bit instruction + 1 byte),
//            paced by both edges of the divider's div_clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9634_spi_master #(
    parameter int   CS_GAP_TICKS = 2,
    parameter logic SDO_IDLE     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_div_clk,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rw,
    input  logic [12:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [7:0]  o_rsp_rdata,
    output logic        o_busy,
    output logic        o_spi_csb,
    output logic        o_spi_sclk,
    output logic        o_spi_sdo,
    output logic        o_spi_sdo_oe,
    input  logic        i_spi_sdi
);

    localparam int c_GAP_W = (CS_GAP_TICKS < 2) ? 1 : $clog2(CS_GAP_TICKS);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(CS_GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t               r_state, w_state;
    logic                 r_div_q;
    logic [23:0]          r_shift, w_shift;
    logic [4:0]           r_bitcnt, w_bitcnt;
    logic                 r_rw, w_rw;
    logic [7:0]           r_rx, w_rx;
    logic [c_GAP_W-1:0]   r_gap, w_gap;
    logic                 r_csb, w_csb;
    logic                 r_sclk, w_sclk;
    logic                 r_sdo, w_sdo;
    logic                 r_oe, w_oe;
    logic                 r_rsp_valid, w_rsp_valid;
    logic [7:0]           r_rsp_rdata, w_rsp_rdata;
    logic                 w_tick;

    // Either div_clk edge is one pacing tick.
    assign w_tick = i_div_clk ^ r_div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_q     <= 1'b0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_rw        <= 1'b0;
            r_rx        <= '0;
            r_gap       <= '0;
            r_csb       <= 1'b1;
            r_sclk      <= 1'b0;
            r_sdo       <= SDO_IDLE;
            r_oe        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state;
            r_div_q     <= i_div_clk;
            r_shift     <= w_shift;
            r_bitcnt    <= w_bitcnt;
            r_rw        <= w_rw;
            r_rx        <= w_rx;
            r_gap       <= w_gap;
            r_csb       <= w_csb;
            r_sclk      <= w_sclk;
            r_sdo       <= w_sdo;
            r_oe        <= w_oe;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_bitcnt    = r_bitcnt;
        w_rw        = r_rw;
        w_rx        = r_rx;
        w_gap       = r_gap;
        w_csb       = r_csb;
        w_sclk      = r_sclk;
        w_sdo       = r_sdo;
        w_oe        = r_oe;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;

        case (r_state)
            S_IDLE: begin
                // Accept does not depend on tick; a coincident tick is dropped.
                if (i_cmd_valid) begin
                    w_shift  = {i_cmd_rw, 2'b00, i_cmd_addr,
                                (i_cmd_rw ? 8'h00 : i_cmd_wdata)};
                    w_rw     = i_cmd_rw;
                    w_bitcnt = '0;
                    w_rx     = '0;
                    w_csb    = 1'b0;
                    w_oe     = 1'b1;
                    w_sdo    = i_cmd_rw;
                    w_state  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_sclk  = 1'b1;
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        w_sclk = 1'b0;
                        // Read byte is sampled just before each falling edge.
                        if (r_rw && r_bitcnt[4]) begin
                            w_rx = {r_rx[6:0], i_spi_sdi};
                        end
                        if (r_bitcnt == 5'd23) begin
                            w_state = S_HOLD;
                        end else begin
                            w_bitcnt = r_bitcnt + 5'd1;
                            w_shift  = {r_shift[22:0], 1'b0};
                            w_sdo    = r_shift[22];
                            if (r_rw && w_bitcnt[4]) begin
                                w_oe  = 1'b0;
                                w_sdo = SDO_IDLE;
                            end
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_csb   = 1'b1;
                    w_oe    = 1'b0;
                    w_sdo   = SDO_IDLE;
                    w_gap   = '0;
                    w_state = S_GAP;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_gap == c_GAP_LAST) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = r_rw ? r_rx : 8'h00;
                        w_state     = S_IDLE;
                    end else begin
                        w_gap = r_gap + 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_spi_csb    = r_csb;
    assign o_spi_sclk   = r_sclk;
    assign o_spi_sdo    = r_sdo;
    assign o_spi_sdo_oe = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_ad9634_spi_master.sv
// ============================================================================
// Module   : tb_ad9634_spi_master
// Brief    : Scoreboard bench for ad9634_spi_master with a 3-wire slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ad9634_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_clk = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        spi_csb;
    logic        spi_sclk;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic        spi_sdi = 1'b0;

    ad9634_spi_master #(.CS_GAP_TICKS(2), .SDO_IDLE(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_div_clk    (div_clk),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_rw     (cmd_rw),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_wdata  (cmd_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_busy       (busy),
        .o_spi_csb    (spi_csb),
        .o_spi_sclk   (spi_sclk),
        .o_spi_sdo    (spi_sdo),
        .o_spi_sdo_oe (spi_sdo_oe),
        .i_spi_sdi    (spi_sdi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] frame;
        logic [23:0] oeh;
        logic [7:0]  rdata;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // div_clk pacing: toggles every 4 clk while running
    logic div_run;
    int   div_cnt  = 0;
    int   tick_cnt = 0;
    always @(negedge clk) begin
        if (div_run) begin
            if (div_cnt == 3) begin
                div_cnt  = 0;
                div_clk  = ~div_clk;
                tick_cnt = tick_cnt + 1;
            end else begin
                div_cnt = div_cnt + 1;
            end
        end
    end

    // Slave/bus monitor
    int          m_rise = 0;
    int          m_fall = 0;
    int          rsp_cnt = 0;
    int          csb_rise_tick = 0;
    int          csb_fall_tick = 0;
    logic [23:0] m_cap = '0;
    logic [23:0] m_oeh = '0;
    logic [7:0]  slave_byte = 8'h00;

    always @(negedge spi_csb) begin
        m_rise = 0;
        m_fall = 0;
        m_cap  = '0;
        m_oeh  = '0;
        csb_fall_tick = tick_cnt;
    end
    always @(posedge spi_csb) csb_rise_tick = tick_cnt;
    always @(posedge spi_sclk) begin
        m_rise = m_rise + 1;
        m_cap  = {m_cap[22:0], spi_sdo};
        m_oeh  = {m_oeh[22:0], spi_sdo_oe};
    end
    always @(negedge spi_sclk) begin
        m_fall = m_fall + 1;
        if (m_fall >= 16 && m_fall <= 23) spi_sdi = slave_byte[23 - m_fall];
    end
    always @(posedge clk) if (rsp_valid) rsp_cnt = rsp_cnt + 1;

    task automatic send(input logic rw, input logic [12:0] a, input logic [7:0] d,
                        input logic [7:0] sl);
        exp_t e;
        int   n = 0;
        slave_byte = sl;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        e.acc   = tick_cnt;
        e.frame = {rw, 2'b00, a, (rw ? 8'h00 : d)};
        e.rdata = rw ? sl : 8'h00;
        e.oeh   = rw ? 24'hFFFF00 : 24'hFFFFFF;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm);
        exp_t e;
        int   n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            if (rsp_valid) break;
            n++;
        end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            $display("FAIL %s rsp_timeout: rsp_valid=%b required 1", nm, rsp_valid);
            miscompares++;
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            $display("FAIL %s sb_empty: unexpected rsp_valid", nm);
            miscompares++;
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (rsp_rdata !== e.rdata) begin
            $display("FAIL %s rdata: got %h required %h", nm, rsp_rdata, e.rdata);
            miscompares++;
        end
        vectors++;
        if (m_cap !== e.frame) begin
            $display("FAIL %s frame: got %h required %h", nm, m_cap, e.frame);
            miscompares++;
        end
        vectors++;
        if (m_rise != 24) begin
            $display("FAIL %s sclk_pulses: got %0d required 24", nm, m_rise);
            miscompares++;
        end
        vectors++;
        if (m_oeh !== e.oeh) begin
            $display("FAIL %s oe_hist: got %h required %h", nm, m_oeh, e.oeh);
            miscompares++;
        end
        vectors++;
        if (tick_cnt - e.acc != 51) begin
            $display("FAIL %s latency: got %0d ticks required 51", nm, tick_cnt - e.acc);
            miscompares++;
        end
        vectors++;
        if (spi_csb !== 1'b1 || spi_sdo_oe !== 1'b0) begin
            $display("FAIL %s bus_idle: csb=%b oe=%b required 1 0", nm, spi_csb, spi_sdo_oe);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL %s rsp_pulse: rsp_valid=%b required 0", nm, rsp_valid);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst     = 1'b1;
        div_run = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (spi_csb !== 1'b1 || spi_sclk !== 1'b0 || spi_sdo_oe !== 1'b0 ||
                spi_sdo !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
                rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL reset_values: %0d bad cycles required 0", bad);
            miscompares++;
        end
        vectors++;
        if (m_rise != 0) begin
            $display("FAIL reset_sclk_edges: got %0d required 0", m_rise);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        send(1'b0, 13'h0014, 8'hA5, 8'h5A);
        wait_rsp("write");
    endtask

    task automatic test_read();
        send(1'b1, 13'h0001, 8'hFF, 8'h8A);
        wait_rsp("read");
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (rsp_rdata !== 8'h8A) begin
            $display("FAIL read_hold: got %h required 8a", rsp_rdata);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n = 0;
        slave_byte = 8'h3D;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 13'h0155;
        cmd_wdata = 8'h96;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        e.acc = tick_cnt; e.frame = 24'h015596; e.rdata = 8'h00; e.oeh = 24'hFFFFFF;
        sb.push_back(e);
        @(negedge clk);
        cmd_rw    = 1'b1;
        cmd_addr  = 13'h0ABC;
        cmd_wdata = 8'h11;
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL b2b_busy: ready=%b busy=%b required 0 1", cmd_ready, busy);
            miscompares++;
        end
        wait_rsp("b2b_first");
        // now one cycle after rsp_valid: second command must be in flight
        vectors++;
        if (busy !== 1'b1 || spi_csb !== 1'b0) begin
            $display("FAIL b2b_accept: busy=%b csb=%b required 1 0", busy, spi_csb);
            miscompares++;
        end
        e.acc = tick_cnt; e.frame = 24'h8ABC00; e.rdata = 8'h3D; e.oeh = 24'hFFFF00;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (csb_fall_tick - csb_rise_tick < 2) begin
            $display("FAIL b2b_csb_gap: got %0d ticks required >=2",
                     csb_fall_tick - csb_rise_tick);
            miscompares++;
        end
        wait_rsp("b2b_second");
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int rc;
        send(1'b0, 13'h0AB0, 8'h77, 8'h00);
        while (m_fall < 10 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (spi_csb !== 1'b1 || spi_sclk !== 1'b0 || spi_sdo_oe !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL midrst_async: csb=%b sclk=%b oe=%b busy=%b required 1 0 0 0",
                     spi_csb, spi_sclk, spi_sdo_oe, busy);
            miscompares++;
        end
        if (sb.size() > 0) void'(sb.pop_back());
        rc = rsp_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        vectors++;
        if (rsp_cnt != rc || rsp_rdata !== 8'h00) begin
            $display("FAIL midrst_no_rsp: pulses=%0d rdata=%h required 0 00",
                     rsp_cnt - rc, rsp_rdata);
            miscompares++;
        end
        send(1'b0, 13'h00FF, 8'h3C, 8'hC3);
        wait_rsp("midrst_after");
    endtask

    task automatic test_stall();
        int   n = 0;
        int   bad = 0;
        logic [4:0] snap;
        send(1'b0, 13'h1234, 8'hC3, 8'h00);
        while (m_rise < 8 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        div_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        snap = {spi_csb, spi_sclk, spi_sdo, spi_sdo_oe, busy};
        repeat (100) begin
            @(posedge clk);
            #1;
            if ({spi_csb, spi_sclk, spi_sdo, spi_sdo_oe, busy} !== snap) bad++;
        end
        vectors++;
        if (bad != 0 || snap[0] !== 1'b1) begin
            $display("FAIL stall_frozen: %0d changes busy=%b required 0 1", bad, snap[0]);
            miscompares++;
        end
        @(negedge clk);
        div_run = 1'b1;
        wait_rsp("stall");
    endtask

    initial begin
        rst       = 1'b1;
        div_run   = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
